alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 4-operation ALU (`somador`, 2-bit operation select). It accepts operation requests over a valid/ready handshake and grants the ALU to one requester at a time. It holds the ALU operands stable for a fixed latency, captures the result, and returns it as a one-cycle response pulse tagged with the requester ID. It sits between the board-level requesters (switch/key front-end, LCD status logic) and the ALU instance.

---
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response signals of the ALU arbiter.
// master = requester/ALU side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int W   = 4,
    parameter int OPW = 2
);
    logic [1:0]       iREQ_VALID;
    logic [1:0]       oREQ_READY;
    logic [2*W-1:0]   iREQ_A;
    logic [2*W-1:0]   iREQ_B;
    logic [2*OPW-1:0] iREQ_OP;
    logic [W-1:0]     oALU_A;
    logic [W-1:0]     oALU_B;
    logic [OPW-1:0]   oALU_SEL;
    logic [W-1:0]     iALU_RES;
    logic [1:0]       oRSP_VALID;
    logic [W-1:0]     oRSP_RES;
    logic             oRSP_ID;
    logic             oBUSY;

    modport master (
        output iREQ_VALID, iREQ_A, iREQ_B, iREQ_OP, iALU_RES,
        input  oREQ_READY, oALU_A, oALU_B, oALU_SEL,
        input  oRSP_VALID, oRSP_RES, oRSP_ID, oBUSY
    );

    modport slave (
        input  iREQ_VALID, iREQ_A, iREQ_B, iREQ_OP, iALU_RES,
        output oREQ_READY, oALU_A, oALU_B, oALU_SEL,
        output oRSP_VALID, oRSP_RES, oRSP_ID, oBUSY
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter/sequencer for the shared ALU.
// Define ALU_ARB_RR_EN for round-robin; default is fixed priority.
module alu_arbiter #(
    parameter int W       = 4,
    parameter int OPW     = 2,
    parameter int ALU_LAT = 1
) (
    input logic          iCLK,
    input logic          iRST,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(ALU_LAT);

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     cnt;
    logic           id;
    logic [1:0]     grant;
    logic [1:0]     ready;
    logic           hs;
    logic           win;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [OPW-1:0] alu_sel;
    logic [W-1:0]   rsp_res;

`ifdef ALU_ARB_RR_EN
    logic last;

    // On contention favour the requester that was not served last.
    always_comb begin
        grant = bus.iREQ_VALID;
        if (&bus.iREQ_VALID) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    // Pointer holds the latest winner; reset value lets requester 0 go first.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            last <= 1'b1;
        end else if (hs) begin
            last <= win;
        end
    end
`else
    // Fixed priority: requester 0 always wins.
    always_comb begin
        grant = 2'b00;
        if (bus.iREQ_VALID[0]) begin
            grant = 2'b01;
        end else if (bus.iREQ_VALID[1]) begin
            grant = 2'b10;
        end
    end
`endif

    assign ready = (state == IDLE && !iRST) ? grant : 2'b00;
    assign hs    = |ready;
    assign win   = ready[1];

    // State register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept, hold for the latency, then one response cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture operands on handshake, count latency, sample the result.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            id      <= 1'b0;
            cnt     <= 4'd0;
            rsp_res <= '0;
        end else if (hs) begin
            alu_a   <= win ? bus.iREQ_A[W +: W] : bus.iREQ_A[0 +: W];
            alu_b   <= win ? bus.iREQ_B[W +: W] : bus.iREQ_B[0 +: W];
            alu_sel <= win ? bus.iREQ_OP[OPW +: OPW]
                           : bus.iREQ_OP[0 +: OPW];
            id      <= win;
            cnt     <= LAT;
        end else if (state == EXEC) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                rsp_res <= bus.iALU_RES;
            end
        end
    end

    assign bus.oREQ_READY = ready;
    assign bus.oALU_A     = alu_a;
    assign bus.oALU_B     = alu_b;
    assign bus.oALU_SEL   = alu_sel;
    assign bus.oRSP_RES   = rsp_res;
    assign bus.oRSP_ID    = id;
    assign bus.oBUSY      = (state != IDLE);
    assign bus.oRSP_VALID = (state == RESP) ? (id ? 2'b10 : 2'b01)
                                            : 2'b00;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter.
// Instance 0 uses ALU_LAT=1, instance 1 uses ALU_LAT=3.
module tb_alu_arbiter;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
`ifdef ALU_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.W(4), .OPW(2)) bus0 ();
    alu_arbiter_if #(.W(4), .OPW(2)) bus1 ();

    alu_arbiter #(.W(4), .OPW(2), .ALU_LAT(LAT0)) u_dut0 (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus0.slave)
    );

    alu_arbiter #(.W(4), .OPW(2), .ALU_LAT(LAT1)) u_dut1 (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus1.slave)
    );

    function automatic logic [3:0] alu_f(logic [3:0] a, logic [3:0] b,
                                         logic [1:0] op);
        case (op)
            2'd0:    return 4'((a + b) & 4'hF);
            2'd1:    return 4'((a - b) & 4'hF);
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // stimulus, indexed [instance][requester]
    logic [1:0] vld [2];
    logic [3:0] ra  [2][2];
    logic [3:0] rb  [2][2];
    logic [1:0] rop [2][2];

    assign bus0.iREQ_VALID = vld[0];
    assign bus0.iREQ_A     = {ra[0][1], ra[0][0]};
    assign bus0.iREQ_B     = {rb[0][1], rb[0][0]};
    assign bus0.iREQ_OP    = {rop[0][1], rop[0][0]};
    assign bus0.iALU_RES   = alu_f(bus0.oALU_A, bus0.oALU_B, bus0.oALU_SEL);
    assign bus1.iREQ_VALID = vld[1];
    assign bus1.iREQ_A     = {ra[1][1], ra[1][0]};
    assign bus1.iREQ_B     = {rb[1][1], rb[1][0]};
    assign bus1.iREQ_OP    = {rop[1][1], rop[1][0]};
    assign bus1.iALU_RES   = alu_f(bus1.oALU_A, bus1.oALU_B, bus1.oALU_SEL);

    // observed outputs, indexed [instance]
    logic [1:0] rdy  [2];
    logic [1:0] rspv [2];
    logic [3:0] oa   [2];
    logic [3:0] ob   [2];
    logic [1:0] osel [2];
    logic [3:0] rres [2];
    logic       rid  [2];
    logic       bsy  [2];

    assign rdy[0]  = bus0.oREQ_READY;
    assign rspv[0] = bus0.oRSP_VALID;
    assign oa[0]   = bus0.oALU_A;
    assign ob[0]   = bus0.oALU_B;
    assign osel[0] = bus0.oALU_SEL;
    assign rres[0] = bus0.oRSP_RES;
    assign rid[0]  = bus0.oRSP_ID;
    assign bsy[0]  = bus0.oBUSY;
    assign rdy[1]  = bus1.oREQ_READY;
    assign rspv[1] = bus1.oRSP_VALID;
    assign oa[1]   = bus1.oALU_A;
    assign ob[1]   = bus1.oALU_B;
    assign osel[1] = bus1.oALU_SEL;
    assign rres[1] = bus1.oRSP_RES;
    assign rid[1]  = bus1.oRSP_ID;
    assign bsy[1]  = bus1.oBUSY;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: cycles until idle, pending result, last winner
    int         m_left [2];
    bit         m_last [2];
    logic [3:0] m_a    [2];
    logic [3:0] m_b    [2];
    logic [1:0] m_op   [2];
    logic [3:0] m_res  [2];
    logic [3:0] m_pend [2];
    logic       m_id   [2];
    logic [1:0] m_hs   [2];

    function automatic logic [1:0] pick(logic [1:0] v, bit last);
        if (v == 2'b11 && RR_MODE) return last ? 2'b01 : 2'b10;
        if (v[0]) return 2'b01;
        if (v[1]) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_step(input int k, input int lat);
        logic [1:0] er;
        logic [1:0] ev;
        logic [1:0] hs;
        logic       id;
        bit         idle;
        if (rst) begin
            chk("rst_ready", 32'(rdy[k]), 32'd0);
            chk("rst_busy", 32'(bsy[k]), 32'd0);
            chk("rst_rspv", 32'(rspv[k]), 32'd0);
            chk("rst_alu", 32'({oa[k], ob[k], osel[k]}), 32'd0);
            chk("rst_res", 32'(rres[k]), 32'd0);
            chk("rst_id", 32'(rid[k]), 32'd0);
            m_left[k] = 0;
            m_last[k] = 1'b1;
            m_a[k]    = '0;
            m_b[k]    = '0;
            m_op[k]   = '0;
            m_res[k]  = '0;
            m_pend[k] = '0;
            m_id[k]   = 1'b0;
            m_hs[k]   = 2'b00;
            return;
        end
        idle = (m_left[k] == 0);
        er = idle ? pick(vld[k], m_last[k]) : 2'b00;
        ev = (m_left[k] == 1) ? (m_id[k] ? 2'b10 : 2'b01) : 2'b00;
        chk("ready", 32'(rdy[k]), 32'(er));
        chk("busy", 32'(bsy[k]), 32'(!idle));
        chk("rsp_valid", 32'(rspv[k]), 32'(ev));
        chk("alu_a", 32'(oa[k]), 32'(m_a[k]));
        chk("alu_b", 32'(ob[k]), 32'(m_b[k]));
        chk("alu_sel", 32'(osel[k]), 32'(m_op[k]));
        chk("rsp_res", 32'(rres[k]), 32'(m_res[k]));
        chk("rsp_id", 32'(rid[k]), 32'(m_id[k]));
        hs = vld[k] & er;
        m_hs[k] = hs;
        if (hs != 2'b00) begin
            id        = hs[1];
            m_id[k]   = id;
            m_a[k]    = ra[k][id];
            m_b[k]    = rb[k][id];
            m_op[k]   = rop[k][id];
            m_pend[k] = alu_f(ra[k][id], rb[k][id], rop[k][id]);
            m_left[k] = lat + 1;
            m_last[k] = id;
        end else if (m_left[k] > 0) begin
            m_left[k]--;
            if (m_left[k] == 1) m_res[k] = m_pend[k];
        end
    endtask

    always @(negedge clk) begin
        model_step(0, LAT0);
        model_step(1, LAT1);
    end

    task automatic run_op(input int k, input logic id, input logic [3:0] a,
                          input logic [3:0] b, input logic [1:0] op,
                          input logic [3:0] exp);
        int lat;
        int n;
        int nb;
        bit hs;
        bit got;
        lat = (k == 0) ? LAT0 : LAT1;
        @(posedge clk);
        #2;
        ra[k][id]  = a;
        rb[k][id]  = b;
        rop[k][id] = op;
        vld[k]     = id ? 2'b10 : 2'b01;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 20) begin
            @(negedge clk);
            n++;
            hs = rdy[k][id];
        end
        chk("hs_wait", 32'(n), 32'd1);
        chk("hs_ready", 32'(rdy[k]), 32'(id ? 2'b10 : 2'b01));
        @(posedge clk);
        #2;
        vld[k] = 2'b00;
        got = 1'b0;
        n   = 0;
        nb  = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bsy[k]) nb++;
            chk("alu_hold", 32'({oa[k], ob[k], osel[k]}), 32'({a, b, op}));
            got = rspv[k][id];
        end
        chk("rsp_lat", 32'(n), 32'(lat + 1));
        chk("rsp_res_d", 32'(rres[k]), 32'(exp));
        chk("rsp_id_d", 32'(rid[k]), 32'(id));
        @(negedge clk);
        chk("busy_end", 32'(bsy[k]), 32'd0);
        chk("busy_cycles", 32'(nb), 32'(lat + 1));
    endtask

    initial begin
        int g[$];
        int n;
        for (int k = 0; k < 2; k++) begin
            vld[k] = 2'b00;
            for (int i = 0; i < 2; i++) begin
                ra[k][i]  = '0;
                rb[k][i]  = '0;
                rop[k][i] = '0;
            end
        end
        rst = 1'b1;
        vld[0] = 2'b11;
        repeat (3) @(posedge clk);
        #2;
        vld[0] = 2'b00;
        rst = 1'b0;

        run_op(0, 1'b0, 4'd3, 4'd5, 2'd0, 4'd8);
        run_op(0, 1'b0, 4'd9, 4'd9, 2'd0, 4'd2);
        run_op(0, 1'b0, 4'd2, 4'd5, 2'd1, 4'd13);
        run_op(0, 1'b1, 4'hC, 4'hA, 2'd2, 4'd8);
        run_op(0, 1'b1, 4'hC, 4'hA, 2'd3, 4'hE);
        run_op(1, 1'b0, 4'd1, 4'd1, 2'd0, 4'd2);

        @(posedge clk);
        #2;
        ra[1][0]  = 4'd5;
        rb[1][0]  = 4'd6;
        rop[1][0] = 2'd0;
        vld[1]    = 2'b01;
        @(negedge clk);
        chk("mid_hs", 32'(rdy[1]), 32'd1);
        @(posedge clk);
        #2;
        vld[1] = 2'b00;
        #1;
        chk("mid_busy", 32'(bsy[1]), 32'd1);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_alu", 32'({oa[k], ob[k], osel[k]}), 32'd0);
            chk("arst_out", 32'({rres[k], rid[k], bsy[k], rspv[k]}), 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                ra[k][i]  = 4'(i + 3);
                rb[k][i]  = 4'(i + 1);
                rop[k][i] = 2'(i);
            end
            vld[k] = 2'b11;
        end
        #1;
        chk("arst_ready", 32'({rdy[0], rdy[1]}), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_g1", 32'(rdy[1]), 32'd1);
        if (rdy[0] != 2'b00) g.push_back(int'(rdy[0][1]));
        n = 0;
        while (g.size() < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (rdy[0] != 2'b00) g.push_back(int'(rdy[0][1]));
        end
        chk("grant_cnt", 32'(g.size()), 32'd4);
        for (int i = 0; i < g.size(); i++) begin
            chk("grant_seq", 32'(g[i]), RR_MODE ? 32'(i % 2) : 32'd0);
        end
        @(posedge clk);
        #2;
        vld[0] = 2'b00;
        vld[1] = 2'b00;
        repeat (8) @(posedge clk);

        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                if (m_hs[0][i]) begin
                    vld[0][i] = 1'($urandom % 2);
                    ra[0][i]  = 4'($urandom);
                    rb[0][i]  = 4'($urandom);
                    rop[0][i] = 2'($urandom);
                end else if (vld[0][i]) begin
                    if ($urandom % 8 == 0) vld[0][i] = 1'b0;
                end else begin
                    ra[0][i]  = 4'($urandom);
                    rb[0][i]  = 4'($urandom);
                    rop[0][i] = 2'($urandom);
                    if ($urandom % 3 == 0) vld[0][i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #2;
        vld[0] = 2'b00;
        repeat (10) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
